instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the CPU's 256x32 instruction ROM port.
- Receives a byte stream from a host link, such as a UART receiver, over a valid/ready handshake.
- Packs the bytes little-endian into 32-bit instruction words and writes them sequentially into instruction memory from address 0.
- Holds the CPU in reset for the whole load, then releases it so fetch starts at PC 0.

Parameters:
- ADDR_W, 8, instruction memory address width; depth = 2^ADDR_W words.
- DATA_W, 32, instruction word width; must be a multiple of 8.

Ports:
- clk  input  1  system clock (MAX10_CLK1_50 at top level)
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; begins a load. Ignored unless in IDLE, DONE or ERR.
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts the byte this cycle
- mem_address  output  ADDR_W  write address to instruction memory
- mem_data  output  DATA_W  write word
- mem_wren  output  1  one-cycle write strobe
- cpu_hold  output  1  drives the CPU reset; high while loading
- busy  output  1  high in LEN, DATA, WRITE, CHK
- done  output  1  sticky; last load completed OK
- error  output  1  sticky; last load failed

Behaviour:
- A byte is accepted on a rising edge with in_valid && in_ready. in_ready is a registered state decode: high only in LEN, DATA, CHK.
- Reset values: in_ready=0, mem_address=0, mem_data=0, mem_wren=0, cpu_hold=1, busy=0, done=0, error=0. The state goes to IDLE. The CPU stays held after reset until a successful load.
- Stream format: one length byte L. Word count N = L, except L=0 means N=256 (clamped to 2^ADDR_W). This is followed by N*4 payload bytes, LSB first.
- IDLE: on start, go to LEN. Clear done and error, set cpu_hold=1, clear the byte index, word counter and mem_address.
- LEN: accept one byte, latch N, go to DATA.
- DATA: accept bytes. Byte k of a word (k=0..3) goes to mem_data[8k+7:8k]. After byte 3 is accepted, go to WRITE.
- WRITE: one cycle with mem_wren=1, in_ready=0, holding the current mem_address and mem_data.
  - Next cycle: increment mem_address (wrapping at 2^ADDR_W) and the word counter.
  - If the counter reaches N, go to CHK when LOADER_CHECKSUM_EN is set, otherwise to DONE. Else go back to DATA.
- DONE: done=1, cpu_hold=0, busy=0. Stay until start.
- ERR: error=1, cpu_hold=1, busy=0. Stay until start.
- Throughput: at most 4 bytes per 5 cycles. Stalls from in_valid=0 are unlimited. There is no timeout.
- start while busy: ignored.
- start in DONE or ERR: acts as in IDLE. cpu_hold rises the next cycle.
- Asynchronous reset mid-load: aborts immediately. Memory contents already written are undefined for the next run, and the CPU stays held.
- mem_address never exceeds N-1 during a load.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - Adds state CHK and an 8-bit running sum, mod 256, of the length byte and all payload bytes.
  - CHK accepts one byte C. If (sum + C) mod 256 == 0, go to DONE, otherwise ERR.
  - Words already written stay in memory; the CPU stays held on ERR.
- Undefined: no CHK state; after the last WRITE go straight to DONE. error can never assert, but the port is kept and tied to 0.

Test Plan:
- Reset, then idle 10 cycles -> cpu_hold=1, mem_wren never asserts, in_ready=0, done=0.
- start, then stream 02, 78 56 34 12, EF BE AD DE with in_valid held high -> mem_wren pulses twice: addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF. Then done=1, cpu_hold=0, and total accepted bytes = 9.
- Same stream with in_valid toggling every other cycle and start pulsed mid-load -> identical writes, and the start pulse has no effect.
- Length byte 00 followed by 1024 bytes -> 256 writes at addresses 0..255, each exactly once, with no wrap write. Then done=1.
- Assert reset after 5 payload bytes -> all outputs return to reset values next edge. A fresh start then loads correctly from address 0.
- LOADER_CHECKSUM_EN: stream 01, 01 00 00 00, checksum FE -> done=1. Checksum FF instead -> error=1, cpu_hold=1, and the word at address 0 was still written.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a little-endian byte stream into words, writes them from address 0
// and holds the CPU in reset until the load completes. Optional trailing checksum: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHK, DONE, ERR} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] byte_idx;
    logic [CNT_W-1:0] word_cnt, word_total;
    logic             accept, last_word, can_start;

    // Length byte 0 means a full memory; larger counts are clamped to the memory depth.
    function automatic logic [CNT_W-1:0] words_of(input logic [7:0] len);
        int n;
        n = (len == 8'd0) ? 256 : int'(len);
        if (n > DEPTH) n = DEPTH;
        return CNT_W'(n);
    endfunction

    assign accept    = in_valid && in_ready;
    assign last_word = ((word_cnt + CNT_W'(1)) == word_total);
    assign can_start = start && ((state == IDLE) || (state == DONE) || (state == ERR));

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] chk_total;
    logic       error_r;

    assign chk_total = sum + in_data;
    assign error     = error_r;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: if (can_start) state_next = LEN;
            LEN:             if (accept) state_next = DATA;
            DATA:            if (accept && (byte_idx == LAST_IDX)) state_next = WRITE;
            WRITE: begin
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK:             if (accept) state_next = (chk_total == 8'd0) ? DONE : ERR;
`else
            CHK:             state_next = DONE;
`endif
            default:         state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            cpu_hold    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            byte_idx    <= '0;
            word_cnt    <= '0;
            word_total  <= '0;
        end else begin
            state    <= state_next;
            // Status outputs are registered decodes of the state being entered.
            in_ready <= (state_next == LEN) || (state_next == DATA) || (state_next == CHK);
            mem_wren <= (state_next == WRITE);
            busy     <= (state_next == LEN) || (state_next == DATA) ||
                        (state_next == WRITE) || (state_next == CHK);
            done     <= (state_next == DONE);
            cpu_hold <= (state_next != DONE);

            if (can_start) begin
                byte_idx    <= '0;
                word_cnt    <= '0;
                mem_address <= '0;
            end
            if (accept && (state == LEN)) word_total <= words_of(in_data);
            if (accept && (state == DATA)) begin
                mem_data[int'(byte_idx)*8 +: 8] <= in_data;
                byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
            end
            // Address stays on the last word so it never points past N-1.
            if (state == WRITE) begin
                word_cnt <= word_cnt + CNT_W'(1);
                if (!last_word) mem_address <= mem_address + ADDR_W'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum     <= 8'd0;
            error_r <= 1'b0;
        end else begin
            error_r <= (state_next == ERR);
            if (can_start) sum <= 8'd0;
            else if (accept && ((state == LEN) || (state == DATA))) sum <= sum + in_data;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus pushes expected memory writes, a monitor pops them.
module tb_instr_mem_loader;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, mem_wren, cpu_hold, busy, done, error;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;

    instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] stream[$];
    int         checks = 0;
    int         failures = 0;
    int         accepted = 0;
    int         writes = 0;

    // Monitor: counts handshakes and checks every write strobe against the scoreboard.
    always @(negedge clk) begin
        if (in_valid && in_ready) accepted++;
        if (mem_wren) begin
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%h required none", mem_address, mem_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.addr !== mem_address || mon_e.data !== mem_data) begin
                    failures++;
                    $display("FAIL mem_write actual addr=%0d data=%h required addr=%0d data=%h",
                             mem_address, mem_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: N words from the length byte, each built from four payload bytes LSB first.
    task automatic model_writes();
        int  n;
        wr_t e;
        n = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
        for (int w = 0; w < n; w++) begin
            e.addr = ADDR_W'(w);
            e.data = {stream[4*w+4], stream[4*w+3], stream[4*w+2], stream[4*w+1]};
            exp_q.push_back(e);
        end
    endtask

    task automatic add_checksum(input bit bad);
`ifdef LOADER_CHECKSUM_EN
        int s = 0;
        foreach (stream[i]) s += int'(stream[i]);
        stream.push_back(8'((256 - (s % 256)) % 256 + (bad ? 1 : 0)));
`else
        if (bad) $display("note: checksum option not built");
`endif
    endtask

    task automatic build_random(input logic [7:0] len);
        int n;
        stream.delete();
        stream.push_back(len);
        n = (len == 8'd0) ? 256 : int'(len);
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
        model_writes();
        add_checksum(1'b0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // gaps: 0 = in_valid held high, 1 = idle cycle before every byte, 2 = random idle cycles
    task automatic send_byte(input logic [7:0] b, input int gaps, input bit inject);
        bit ok = 1'b0;
        int budget = 0;
        if (gaps == 1 || (gaps == 2 && $urandom_range(1, 0) == 1)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        if (inject && $urandom_range(3, 0) == 0) start = 1'b1;
        while (!ok && budget < 50) begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            budget++;
        end
        check("byte_accept", ok, 1'b1);
    endtask

    task automatic wait_end(input string tag, input bit ok_req);
        int n = 0;
        @(negedge clk);
        while (!(done || error) && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, ok_req);
        check({tag, "_error"}, error, !ok_req);
        check({tag, "_cpu_hold"}, cpu_hold, !ok_req);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic do_load(input string tag, input int gaps, input bit inject, input bit ok_req);
        int base = accepted;
        int n_bytes = stream.size();
        pulse_start();
        check({tag, "_hold_after_start"}, cpu_hold, 1'b1);
        check({tag, "_done_cleared"}, done, 1'b0);
        foreach (stream[i]) send_byte(stream[i], gaps, inject);
        in_valid = 1'b0;
        wait_end(tag, ok_req);
        check({tag, "_accepted"}, accepted - base, n_bytes);
    endtask

    task automatic directed_stream();
        stream.delete();
        stream = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        model_writes();
        add_checksum(1'b0);
    endtask

    initial begin
        int wr0;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_cpu_hold", cpu_hold, 1'b1);
        check("idle_in_ready", in_ready, 1'b0);
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_no_writes", writes, 0);

        directed_stream();
        check("directed_expected_words", exp_q.size(), 2);
        do_load("directed", 0, 1'b0, 1'b1);

        directed_stream();
        do_load("toggle_valid", 1, 1'b1, 1'b1);

        for (int r = 0; r < 5; r++) begin
            build_random(8'($urandom_range(6, 1)));
            do_load("random", 2, 1'b1, 1'b1);
        end

        wr0 = writes;
        build_random(8'h00);
        do_load("full_depth", 0, 1'b0, 1'b1);
        check("full_depth_writes", writes - wr0, 256);

        // Abort mid-load after five payload bytes.
        build_random(8'h03);
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream[i], 0, 1'b0);
        reset = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_mem_address", mem_address, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_mem_wren", mem_wren, 1'b0);
        check("rst_cpu_hold", cpu_hold, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        directed_stream();
        do_load("after_reset", 0, 1'b0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        stream.delete();
        stream = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFE};
        model_writes();
        do_load("chk_good", 0, 1'b0, 1'b1);
        stream.delete();
        stream = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF};
        model_writes();
        wr0 = writes;
        do_load("chk_bad", 0, 1'b0, 1'b0);
        check("chk_bad_word_written", writes - wr0, 1);
`endif

        repeat (3) @(negedge clk);
        check("final_no_stray_writes", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
